// File: rtl/host_cmd_pkg.sv
// host_cmd_pkg: shared definitions for the UART register/ALU command protocol.
// The opcodes, command-type encoding and frame lengths are shared with the
// system controller's decoder, so this package must stay in step with it.
package host_cmd_pkg;

    // Frame opcodes (first byte of each frame)
    localparam logic [7:0] CMD_REG_WR  = 8'hAA;
    localparam logic [7:0] CMD_REG_RD  = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        TYPE_REG_WR  = 2'd0,
        TYPE_REG_RD  = 2'd1,
        TYPE_ALU_OP  = 2'd2,
        TYPE_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    // Frame lengths in bytes, opcode included
    localparam logic [2:0] LEN_REG_WR  = 3'd3;
    localparam logic [2:0] LEN_REG_RD  = 3'd2;
    localparam logic [2:0] LEN_ALU_OP  = 3'd4;
    localparam logic [2:0] LEN_ALU_NOP = 3'd2;

    function automatic logic [2:0] frame_len(cmd_type_e t);
        case (t)
            TYPE_REG_WR: return LEN_REG_WR;
            TYPE_REG_RD: return LEN_REG_RD;
            TYPE_ALU_OP: return LEN_ALU_OP;
            default:     return LEN_ALU_NOP;
        endcase
    endfunction

    function automatic logic [7:0] opcode(cmd_type_e t);
        case (t)
            TYPE_REG_WR: return CMD_REG_WR;
            TYPE_REG_RD: return CMD_REG_RD;
            TYPE_ALU_OP: return CMD_ALU_OP;
            default:     return CMD_ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/host_cmd_master_if.sv
// host_cmd_master_if: command request, tx byte stream, rx byte stream and
// response signals of the host command master, bundled for one connection.
interface host_cmd_master_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    host_cmd_pkg::cmd_type_e cmd_type;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [DATA_WIDTH-1:0]  cmd_data;
    logic [DATA_WIDTH-1:0]  cmd_op_a;
    logic [DATA_WIDTH-1:0]  cmd_op_b;
    logic [3:0]             cmd_alu_fun;
    logic [DATA_WIDTH-1:0]  tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [DATA_WIDTH-1:0]  rx_data;
    logic                   rx_valid;
    logic                   rsp_valid;
    logic [DATA_WIDTH-1:0]  rsp_data;
    logic                   rsp_err;
    logic                   stray_rx;

    modport master (
        input  cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_op_a, cmd_op_b,
               cmd_alu_fun, tx_ready, rx_data, rx_valid,
        output cmd_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_err,
               stray_rx
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_op_a, cmd_op_b,
               cmd_alu_fun, tx_ready, rx_data, rx_valid,
        input  cmd_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_err,
               stray_rx
    );
endinterface

// File: rtl/host_cmd_master_rsp_timer.sv
// rsp_timer: response wait counter. Cleared on entry to the wait state,
// counts enabled cycles and flags the last allowed cycle of the wait window.
module rsp_timer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Terminal on the TIMEOUT_CYCLES-th cycle spent waiting (count starts at 0)
    assign term_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Next count: clear wins, then saturate at terminal
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !term_o)
            cnt_d = cnt_q + CW'(1);
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/host_cmd_master.sv
// host_cmd_master: serializes one command into a UART frame and returns the
// single-byte response. Optional response timeout: HOST_CMD_MASTER_TIMEOUT_EN.
module host_cmd_master
    import host_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic               clk,
    input logic               rst,
    host_cmd_master_if.master bus
);
    state_e                state_q;
    logic                  cmd_ready_q;
    logic                  tx_valid_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  is_wr_q;
    logic [1:0]            idx_q;
    logic [1:0]            last_q;
    logic [DATA_WIDTH-1:0] frame_q [1:3];
    logic [DATA_WIDTH-1:0] frame_d [0:3];
    logic                  accept, tx_hs, last_hs, tmr_term;

    assign accept  = (state_q == ST_IDLE) && bus.cmd_valid && cmd_ready_q;
    assign tx_hs   = (state_q == ST_SEND) && bus.tx_ready;
    assign last_hs = tx_hs && (idx_q == last_q);

    // Frame bytes for the command on the request bus; unused slots are zero
    always_comb begin
        for (int i = 0; i < 4; i++) frame_d[i] = '0;
        frame_d[0] = DATA_WIDTH'(opcode(bus.cmd_type));
        case (bus.cmd_type)
            TYPE_REG_WR: begin
                frame_d[1] = DATA_WIDTH'(bus.cmd_addr);
                frame_d[2] = bus.cmd_data;
            end
            TYPE_REG_RD:
                frame_d[1] = DATA_WIDTH'(bus.cmd_addr);
            TYPE_ALU_OP: begin
                frame_d[1] = bus.cmd_op_a;
                frame_d[2] = bus.cmd_op_b;
                frame_d[3] = DATA_WIDTH'(bus.cmd_alu_fun);
            end
            default:
                frame_d[1] = DATA_WIDTH'(bus.cmd_alu_fun);
        endcase
    end

    // Capture the remaining frame bytes at accept; byte 0 goes straight to tx_data
    always_ff @(posedge clk) begin
        if (accept)
            for (int i = 1; i < 4; i++) frame_q[i] <= frame_d[i];
    end

`ifdef HOST_CMD_MASTER_TIMEOUT_EN
    logic rsp_err_q;

    rsp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rsp_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (last_hs && !is_wr_q),
        .en_i   (state_q == ST_WAIT_RSP),
        .term_o (tmr_term)
    );
    assign bus.rsp_err = rsp_err_q;
`else
    assign tmr_term    = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // Main FSM with registered handshake and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            is_wr_q     <= 1'b0;
            idx_q       <= '0;
            last_q      <= '0;
`ifdef HOST_CMD_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (accept) begin
                    is_wr_q     <= (bus.cmd_type == TYPE_REG_WR);
                    last_q      <= 2'(frame_len(bus.cmd_type) - 3'd1);
                    idx_q       <= '0;
                    tx_data_q   <= frame_d[0];
                    tx_valid_q  <= 1'b1;
                    cmd_ready_q <= 1'b0;
                    state_q     <= ST_SEND;
                end
                ST_SEND: if (last_hs) begin
                    tx_valid_q <= 1'b0;
                    tx_data_q  <= '0;
                    if (is_wr_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
`ifdef HOST_CMD_MASTER_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT_RSP;
                    end
                end else if (tx_hs) begin
                    idx_q     <= idx_q + 2'd1;
                    tx_data_q <= frame_q[idx_q + 2'd1];
                end
                // A response byte on the terminal cycle beats the timeout
                ST_WAIT_RSP: if (bus.rx_valid) begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= bus.rx_data;
`ifdef HOST_CMD_MASTER_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state_q     <= ST_RESP;
                end else if (tmr_term) begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
`ifdef HOST_CMD_MASTER_TIMEOUT_EN
                    rsp_err_q   <= 1'b1;
`endif
                    state_q     <= ST_RESP;
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    // Bytes outside the wait state are dropped and flagged in the same cycle
    assign bus.stray_rx  = !rst && bus.rx_valid && (state_q != ST_WAIT_RSP);
endmodule

// File: tb/tb_host_cmd_master.sv
// tb_host_cmd_master: directed and randomized commands checked against a
// frame/response model derived from the protocol rules.
module tb_host_cmd_master;
    import host_cmd_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    host_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    host_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // stall: 0 = tx_ready high, 1 = 1-0-1 alternating, 2 = random
    // delay: cycles in WAIT_RSP before the response byte; no_rx: never respond
    task automatic do_cmd(input int typ, input logic [3:0] addr, input logic [7:0] data,
                          input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                          input logic [7:0] rsp, input int stall, input int delay,
                          input bit stray_send, input bit no_rx);
        logic [7:0] fr [4];
        int len, k, cyc, n;
        // Reference frame built from the protocol byte order
        fr = '{default: 8'h00};
        case (typ)
            0: begin fr[0] = 8'hAA; fr[1] = {4'h0, addr}; fr[2] = data; len = 3; end
            1: begin fr[0] = 8'hBB; fr[1] = {4'h0, addr}; len = 2; end
            2: begin fr[0] = 8'hCC; fr[1] = a; fr[2] = b; fr[3] = {4'h0, fun}; len = 4; end
            default: begin fr[0] = 8'hDD; fr[1] = {4'h0, fun}; len = 2; end
        endcase
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin tick; n++; end
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_type    = cmd_type_e'(typ);
        bus.cmd_addr    = addr;
        bus.cmd_data    = data;
        bus.cmd_op_a    = a;
        bus.cmd_op_b    = b;
        bus.cmd_alu_fun = fun;
        bus.cmd_valid   = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = $urandom;
        bus.cmd_op_a  = $urandom;
        k = 0;
        cyc = 0;
        while (k < len && cyc < 200) begin
            case (stall)
                0: bus.tx_ready = 1'b1;
                1: bus.tx_ready = (cyc % 2 == 0);
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (stray_send && cyc == 0) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = 8'h55;
            end
            #1;
            chk("tx_valid", bus.tx_valid, 1);
            chk($sformatf("tx_data[%0d]", k), bus.tx_data, fr[k]);
            chk("cmd_ready_busy", bus.cmd_ready, 0);
            if (stray_send && cyc == 0) chk("stray_in_send", bus.stray_rx, 1);
            if (bus.tx_ready) k++;
            tick;
            bus.rx_valid = 1'b0;
            cyc++;
        end
        chk("frame_len", k, len);
        bus.tx_ready = 1'b0;
        if (typ == 0) begin
            #1;
            chk("wr_rsp_valid", bus.rsp_valid, 1);
            chk("wr_rsp_data", bus.rsp_data, 0);
            chk("wr_rsp_err", bus.rsp_err, 0);
            chk("tx_valid_after", bus.tx_valid, 0);
        end else if (no_rx) begin
            for (int i = 0; i < TO; i++) begin
                #1;
                chk("to_wait_no_rsp", bus.rsp_valid, 0);
                tick;
            end
            #1;
            chk("to_rsp_valid", bus.rsp_valid, 1);
            chk("to_rsp_err", bus.rsp_err, 1);
            chk("to_rsp_data", bus.rsp_data, 0);
        end else begin
            for (int i = 0; i < delay; i++) begin
                #1;
                chk("wait_no_rsp", bus.rsp_valid, 0);
                chk("wait_tx_valid", bus.tx_valid, 0);
                tick;
            end
            bus.rx_valid = 1'b1;
            bus.rx_data  = rsp;
            #1;
            chk("rx_used_not_stray", bus.stray_rx, 0);
            tick;
            bus.rx_valid = 1'b0;
            #1;
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_data", bus.rsp_data, rsp);
            chk("rsp_err", bus.rsp_err, 0);
        end
        tick;
        #1;
        chk("rsp_pulse_end", bus.rsp_valid, 0);
        chk("cmd_ready_back", bus.cmd_ready, 1);
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_type = TYPE_REG_WR; bus.cmd_addr = 0;
        bus.cmd_data = 0; bus.cmd_op_a = 0; bus.cmd_op_b = 0; bus.cmd_alu_fun = 0;
        bus.tx_ready = 0; bus.rx_data = 0; bus.rx_valid = 0;
        rst = 1'b0;
        #2 rst = 1'b1;
        tick; tick;
        // Reset state
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_stray", bus.stray_rx, 0);
        rst = 1'b0;
        tick;

        // Directed cases from the protocol examples
        do_cmd(0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0, 8'h00, 0, 0, 0, 0);
        do_cmd(1, 4'd2, 8'h00, 8'h00, 8'h00, 4'd0, 8'h81, 1, 2, 0, 0);
        do_cmd(2, 4'd0, 8'h00, 8'h10, 8'h20, 4'd0, 8'h30, 0, 1, 0, 0);
        do_cmd(3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd3, 8'h5A, 0, 0, 0, 0);

        // Stray byte in IDLE, then one during SEND; real response still lands
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        #1;
        chk("stray_in_idle", bus.stray_rx, 1);
        tick;
        bus.rx_valid = 1'b0;
        #1;
        chk("stray_clear", bus.stray_rx, 0);
        chk("stray_no_rsp", bus.rsp_valid, 0);
        tick;
        do_cmd(1, 4'd7, 8'h00, 8'h00, 8'h00, 4'd0, 8'h66, 0, 3, 1, 0);

        // Response on the last cycle of the wait window (normal response either way)
        do_cmd(1, 4'd1, 8'h00, 8'h00, 8'h00, 4'd0, 8'hA5, 0, TO - 1, 0, 0);
`ifdef HOST_CMD_MASTER_TIMEOUT_EN
        do_cmd(3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd9, 8'h00, 0, 0, 0, 1);
        do_cmd(2, 4'd0, 8'h00, 8'h01, 8'h02, 4'd4, 8'h00, 2, 0, 0, 1);
`endif

        // Reset in the middle of an ALU_OP frame
        bus.cmd_type = TYPE_ALU_OP; bus.cmd_op_a = 8'h11; bus.cmd_op_b = 8'h22;
        bus.cmd_alu_fun = 4'd1; bus.cmd_valid = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        bus.tx_ready  = 1'b1;
        tick;
        tick;
        bus.tx_ready = 1'b0;
        #1;
        chk("pre_rst_tx_valid", bus.tx_valid, 1);
        chk("pre_rst_tx_data", bus.tx_data, 8'h22);
        rst = 1'b1;
        #1;
        chk("midrst_tx_valid", bus.tx_valid, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("postrst_no_rsp", bus.rsp_valid, 0);
            chk("postrst_tx_idle", bus.tx_valid, 0);
            tick;
        end
        do_cmd(1, 4'd3, 8'h00, 8'h00, 8'h00, 4'd0, 8'hC3, 0, 1, 0, 0);

        // Randomized commands against the frame/response model
        for (int r = 0; r < 25; r++) begin
            do_cmd(int'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), 4'($urandom), 8'($urandom), 2,
                   int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/host_cmd_master.md
# host_cmd_master

Host-side initiator for the UART register/ALU command protocol. It accepts one command at a time on a parallel request interface and serializes it into a frame of command bytes on a byte-stream output that feeds a UART transmitter. It then collects the single-byte response from a UART receiver's byte stream and returns it with a completion/error status. It sits in test harnesses and host-bridge designs, opposite the on-chip system controller.

## Interface
- DATA_WIDTH, 8, byte/operand width
- ADDR_WIDTH, 4, register-file address width; zero-extended into one byte
- TIMEOUT_CYCLES, 65535, response wait limit in clk cycles; ≥ 1

- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_type  in  2  0=REG_WR, 1=REG_RD, 2=ALU_OP (with operands), 3=ALU_NOP (no operands)
- cmd_addr  in  ADDR_WIDTH  register address (REG_WR, REG_RD)
- cmd_data  in  DATA_WIDTH  write data (REG_WR)
- cmd_op_a, cmd_op_b  in  DATA_WIDTH each  operands (ALU_OP)
- cmd_alu_fun  in  4  ALU function (ALU_OP, ALU_NOP)
- tx_data  out  DATA_WIDTH  frame byte
- tx_valid  out  1  byte valid; held with tx_data stable until accepted
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
- rx_data  in  DATA_WIDTH  received byte
- rx_valid  in  1  single-cycle pulse, rx_data valid
- rsp_valid  out  1  single-cycle completion pulse
- rsp_data  out  DATA_WIDTH  response byte; 0 for REG_WR or on error
- rsp_err  out  1  response timeout; qualified by rsp_valid
- stray_rx  out  1  single-cycle pulse: rx byte arrived outside WAIT_RSP; byte discarded

## Operation
- Frames, in byte order:
  - REG_WR: 0xAA, addr, data
  - REG_RD: 0xBB, addr
  - ALU_OP: 0xCC, A, B, fun
  - ALU_NOP: 0xDD, fun
- addr and fun are zero-extended to DATA_WIDTH.
- States: IDLE, SEND, WAIT_RSP, RESP.
- IDLE: on cmd_valid && cmd_ready, register all cmd fields and the frame length (2–4), clear the byte index, and go to SEND.
- SEND: tx_data = frame[index]. Each handshake increments the index. On the handshake of the last byte:
  - REG_WR goes to RESP with rsp_data = 0.
  - All other types go to WAIT_RSP.
- WAIT_RSP: on the first rx_valid, capture rx_data and go to RESP.
- RESP: rsp_valid = 1 for one cycle, then return to IDLE.
- Bytes received in IDLE, SEND or RESP are dropped and pulse stray_rx in the same cycle. Only the first byte in WAIT_RSP is used.
- Reset values: state IDLE, cmd_ready = 1, tx_valid = 0, tx_data = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, stray_rx = 0.
- Reset asserted mid-frame: tx_valid drops immediately and the frame is abandoned. No rsp_valid is produced for that command.

## Timing
- Command accepted in cycle N → tx_valid = 1 with byte 0 from cycle N+1.
- With tx_ready tied high, byte k is presented in cycle N+1+k. No bubbles between bytes.
- REG_WR completion: rsp_valid in the cycle after the last byte's handshake.
- Response completion: rsp_valid in the cycle after rx_valid. rsp_data and rsp_err are registered outputs, valid only while rsp_valid = 1.
- cmd_ready is low from N+1 until the cycle after rsp_valid. The earliest next accept is the cycle after rsp_valid.
- tx_valid never drops without a handshake, except on reset.

## Configuration
- HOST_CMD_MASTER_TIMEOUT_EN defined:
  - A counter, cleared on entry to WAIT_RSP, counts clk cycles.
  - When it reaches TIMEOUT_CYCLES without rx_valid, go to RESP with rsp_err = 1 and rsp_data = 0.
  - rx_valid in the same cycle as the terminal count wins: normal response, rsp_err = 0.
- Undefined: no counter. WAIT_RSP waits indefinitely and rsp_err is tied to 0.

## Structure
- Shared package host_cmd_pkg contains:
  - opcode constants CMD_REG_WR = 0xAA, CMD_REG_RD = 0xBB, CMD_ALU_OP = 0xCC, CMD_ALU_NOP = 0xDD
  - the cmd_type encoding
  - the state encoding
  - frame lengths per type
- The system controller's decoder uses the same package.
- One sub-module: rsp_timer (load/clear, count enable, terminal flag). It is instantiated only under HOST_CMD_MASTER_TIMEOUT_EN.

## Test plan
- REG_WR addr = 5, data = 0x3C, tx_ready = 1 → tx bytes 0xAA, 0x05, 0x3C on consecutive cycles; rsp_valid one cycle later with rsp_data = 0, rsp_err = 0.
- REG_RD addr = 2, tx_ready toggled 1-0-1 → bytes 0xBB, 0x02 held stable through the stalls; rx_valid with 0x81 → rsp_valid next cycle with rsp_data = 0x81.
- ALU_OP A = 0x10, B = 0x20, fun = 0 → bytes 0xCC, 0x10, 0x20, 0x00; response 0x30 returned. ALU_NOP fun = 3 → bytes 0xDD, 0x03.
- rx_valid 0x55 during SEND and in IDLE → stray_rx pulses; the subsequent response 0x66 is returned as rsp_data = 0x66.
- Timeout enabled, TIMEOUT_CYCLES = 16, no rx → rsp_valid with rsp_err = 1 after 16 cycles in WAIT_RSP. A rerun with rx_valid on the terminal cycle gives rsp_err = 0.
- rst asserted after byte 1 of ALU_OP → tx_valid low in the same cycle, cmd_ready = 1, no rsp_valid; a new REG_RD afterwards completes normally.
